// File: rtl/seg_display_ctrl.sv
// Eight-digit multiplexed seven-segment driver with frame-sampled display value
// and saturating running/stalled cycle counters.
module seg_display_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data_in,
  input  logic [31:0]      pc_in,
  input  logic             enable,
  input  logic [1:0]       sel,
  input  logic             blank_lz,
  input  logic             clr_cnt,
  output logic [7:0]       seg,
  output logic [7:0]       an,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stl_q, stl_d;

  logic        tick;
  logic [31:0] src;
  logic [31:0] upper;
  logic [3:0]  nib;
  logic        blank;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (presc_q == PW'(SCAN_DIV - 1));
    presc_d  = tick ? '0 : presc_q + PW'(1);
    idx_d    = tick ? idx_q + 3'd1 : idx_q;

    case (sel)
      2'b00:   src = data_in;
      2'b01:   src = pc_in;
      2'b10:   src = 32'(cyc_q);
      default: src = 32'(stl_q);
    endcase
    shadow_d = (tick && idx_q == 3'd7) ? src : shadow_q;

    // A digit is a leading zero when it and every more-significant nibble are zero.
    nib   = shadow_q[{idx_q, 2'b00} +: 4];
    upper = shadow_q >> {idx_q, 2'b00};
    blank = blank_lz && (idx_q != 3'd0) && (upper == 32'd0);

    an_d  = ~(8'd1 << idx_q);
    seg_d = {~((idx_q == 3'd0) && !enable), blank ? 7'h7F : hex7(nib)};

    cyc_d = cyc_q;
    stl_d = stl_q;
    if (clr_cnt) begin
      cyc_d = '0;
      stl_d = '0;
    end else if (enable) begin
      cyc_d = sat_inc(cyc_q);
    end else begin
      stl_d = sat_inc(stl_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      an_q     <= 8'hFF;
      seg_q    <= 8'hFF;
      cyc_q    <= '0;
      stl_q    <= '0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      cyc_q    <= cyc_d;
      stl_q    <= stl_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign cycle_cnt = cyc_q;
  assign stall_cnt = stl_q;

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Downstream consumer of the syscall pause/display stage.
- Takes the latched 32-bit display value, the current PC and the PC enable. Drives an 8-digit multiplexed, active-low seven-segment display.
- Keeps running-cycle and stalled-cycle counters, selectable for display.
- The display value is frame-sampled so digits never tear mid-scan.

Parameters:
SCAN_DIV, 100000, clk cycles each digit is lit (minimum 2)
CNT_W, 32, width of cycle_cnt/stall_cnt (bench uses 4 for saturation test)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
data_in  input  32  display value from syscall display register
pc_in  input  32  current PC
enable  input  1  PC enable from pause stage (1 = running, 0 = paused/stopped)
sel  input  2  source: 00 data_in, 01 pc_in, 10 cycle_cnt (zero-extended), 11 stall_cnt (zero-extended)
blank_lz  input  1  1 = blank leading zero digits
clr_cnt  input  1  synchronous clear of both counters
seg  output  8  active-low cathodes {dp,g,f,e,d,c,b,a}
an  output  8  active-low anodes, an[i] = digit i, digit 0 rightmost / least-significant nibble
cycle_cnt  output  CNT_W  clocks with enable=1
stall_cnt  output  CNT_W  clocks with enable=0

Behaviour:
- Reset (rst=0, asynchronous, effective mid-operation):
  - prescaler=0, idx=0, shadow=0
  - an=8'hFF, seg=8'hFF
  - cycle_cnt=0, stall_cnt=0
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick=1 for the single cycle where prescaler==SCAN_DIV-1.
- Digit index idx (3 bits):
  - Increments on tick; wraps 7->0.
  - Frame = 8*SCAN_DIV clocks.
- Shadow register:
  - Loads the sel-selected source on a tick with idx==7 (frame boundary), same edge as idx wraps to 0.
  - A sel or data change mid-frame takes effect only at the next frame boundary.
  - shadow stays 0 until the first frame boundary after reset.
- Output registers:
  - an/seg are registered from idx and shadow every clk; one-cycle latency after an idx change.
  - an = ~(1<<idx), exactly one anode low at any time after the first post-reset clock.
- Hex decode of nibble shadow[4*idx+3:4*idx], giving seg[6:0] (gfedcba, active low):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Leading-zero blanking:
  - Digit i>0 is blanked when blank_lz=1 and nibbles i..7 of shadow are all zero.
  - Blanked digit: seg[6:0]=7'h7F, anode still driven.
  - Digit 0 is never blanked.
  - blank_lz is sampled combinationally each clk (no frame delay).
- Decimal point seg[7]:
  - 0 (lit) only on digit 0 while enable==0, as the paused/halted indicator.
  - 1 on all other digits.
  - Follows enable with one clk latency.
- Counters:
  - Each clk, cycle_cnt+=1 if enable=1, else stall_cnt+=1.
  - Both saturate at all-ones; no wrap.
  - clr_cnt=1 clears both on that edge; clear has priority over increment.
- sel=10/11 display the counter value at the frame-boundary edge, zero-extended to 32 bits, or truncated to 32 bits if CNT_W>32.

Test Plan:
1. Hold rst=0, toggle clk -> an=FF, seg=FF, cycle_cnt=stall_cnt=0. Release rst -> next clk: an=FE, seg=C0 (shadow 0).
2. SCAN_DIV=4, sel=00, data_in=32'h12345678, enable=1, blank_lz=0; run past first frame boundary:
   - digit 0: an=FE, seg=80
   - digit 1: an=FD, seg=F8
   - digit 7: an=7F, seg=F9
   - each digit is held 4 clks; the pattern repeats every 32 clks.
3. data_in=32'h0000002A, blank_lz=1, after frame boundary:
   - digit 0: seg=88; digit 1: seg=A4
   - digits 2..7: seg=FF with their anodes low in turn
   - data_in=0 -> digit 0 seg=C0, all other digits FF.
4. clr_cnt pulse, then enable=1 for 5 clks and 0 for 10 clks:
   - cycle_cnt=5, stall_cnt=10.
   - While enable=0, digit 0 seg[7]=0.
   - clr_cnt and enable=1 on the same edge -> both counters 0.
5. CNT_W=4, enable=1 for 20 clks -> cycle_cnt saturates at 4'hF and holds. sel=10 -> after frame boundary, digit 0 seg=8E, digits 1..7 seg=C0 (blank_lz=0).
6. Mid-frame: change sel 00->01 with pc_in=32'h00003000 -> display unchanged until frame boundary, then shows 00003000. Assert rst=0 mid-digit -> an/seg=FF immediately without a clk edge, and the counters clear.
